// File: rtl/dual_issue_fetch_buffer_pkg.sv
// dual_issue_fetch_buffer_pkg: shared fetch-path types and default sizing.
//   instruction_s    : RV32 instruction word split into its base-format fields
//   fetch_entry_s    : one buffered fetch result {pc, instr} at the default PC width
//   fetch_buf_els_gp : default fetch buffer depth
//   pc_width_gp      : default word-address PC width (byte PC >> 2)
package dual_issue_fetch_buffer_pkg;

   localparam int fetch_buf_els_gp = 4;
   localparam int pc_width_gp      = 22;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] op;
   } instruction_s;

   typedef struct packed {
      logic [pc_width_gp-1:0] pc;
      instruction_s           instr;
   } fetch_entry_s;

endpackage

// File: rtl/dual_issue_fetch_buffer_if.sv
// dual_issue_fetch_buffer_if: fetch-side enqueue and decode-side dual read/retire bundle.
//   enq_v_i/enq_instr_i/enq_pc_i/enq_ready_o : fetch handshake
//   instr_o/pc_o/v_o                         : two oldest slots (index 0 = older)
//   deq_count_i                              : instructions consumed this cycle (0..2)
//   flush_i                                  : discard all entries
//   count_o                                  : occupancy
//   slave modport = buffer, master modport = fetch/decode side
interface dual_issue_fetch_buffer_if
   import dual_issue_fetch_buffer_pkg::*;
#(
   parameter int els_p      = fetch_buf_els_gp,
   parameter int pc_width_p = pc_width_gp
);
   logic                          enq_v_i;
   instruction_s                  enq_instr_i;
   logic [pc_width_p-1:0]         enq_pc_i;
   logic                          enq_ready_o;
   instruction_s [1:0]            instr_o;
   logic [1:0][pc_width_p-1:0]    pc_o;
   logic [1:0]                    v_o;
   logic [1:0]                    deq_count_i;
   logic                          flush_i;
   logic [$clog2(els_p+1)-1:0]    count_o;

   modport slave (
      input  enq_v_i, enq_instr_i, enq_pc_i, deq_count_i, flush_i,
      output enq_ready_o, instr_o, pc_o, v_o, count_o
   );

   modport master (
      output enq_v_i, enq_instr_i, enq_pc_i, deq_count_i, flush_i,
      input  enq_ready_o, instr_o, pc_o, v_o, count_o
   );
endinterface

// File: rtl/dual_issue_fetch_buffer.sv
// dual_issue_fetch_buffer: circular instruction queue presenting the two oldest entries to a dual decoder.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset (pointers and occupancy only)
//   bus       : dual_issue_fetch_buffer_if.slave (enqueue, two read slots, retire count, flush, occupancy)
module dual_issue_fetch_buffer
   import dual_issue_fetch_buffer_pkg::*;
#(
   parameter int els_p      = fetch_buf_els_gp,
   parameter int pc_width_p = pc_width_gp
) (
   input logic                      clk_i,
   input logic                      reset_n_i,
   dual_issue_fetch_buffer_if.slave bus
);
   localparam int ptr_w_lp = $clog2(els_p);
   localparam int cnt_w_lp = $clog2(els_p+1);

   typedef struct packed {
      logic [pc_width_p-1:0] pc;
      instruction_s          instr;
   } entry_s;

   entry_s                mem [els_p];
   logic [ptr_w_lp-1:0]   rptr, wptr, rptr1;
   logic [cnt_w_lp-1:0]   cnt;
   logic [1:0]            avail, dq, d;
   logic                  ready, enq_fire;

   // Retire count is clamped to what is actually presented; 3 behaves as 2.
   assign avail    = (cnt >= cnt_w_lp'(2)) ? 2'd2 : cnt[1:0];
   assign dq       = (bus.deq_count_i == 2'd3) ? 2'd2 : bus.deq_count_i;
   assign d        = (dq > avail) ? avail : dq;
   // Ready comes from registered occupancy only, so a full buffer never accepts even while draining.
   assign ready    = cnt < cnt_w_lp'(els_p);
   assign enq_fire = bus.enq_v_i & ready & ~bus.flush_i;
   assign rptr1    = rptr + ptr_w_lp'(1);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else if (bus.flush_i) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         rptr <= rptr + ptr_w_lp'(d);
         wptr <= wptr + ptr_w_lp'(enq_fire);
         cnt  <= cnt + cnt_w_lp'(enq_fire) - cnt_w_lp'(d);
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq_fire) mem[wptr] <= '{pc: bus.enq_pc_i, instr: bus.enq_instr_i};
   end

   assign bus.enq_ready_o = ready;
   assign bus.count_o     = cnt;
   assign bus.v_o         = {cnt >= cnt_w_lp'(2), cnt != '0};
   assign bus.instr_o[0]  = mem[rptr].instr;
   assign bus.instr_o[1]  = mem[rptr1].instr;
   assign bus.pc_o[0]     = mem[rptr].pc;
   assign bus.pc_o[1]     = mem[rptr1].pc;

`ifndef SYNTHESIS
   a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.deq_count_i != 2'd3)
      else $error("deq_count_i = 3 is illegal");

   // Fetch is sequential within a flush epoch, so the two slots are always adjacent PCs.
   a_pc_seq: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.v_o[1] |-> (bus.pc_o[1] == bus.pc_o[0] + pc_width_p'(1)))
      else $error("slot PCs not sequential");
`endif

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// tb_dual_issue_fetch_buffer: directed tests for the dual-issue fetch buffer.
module tb_dual_issue_fetch_buffer;
   import dual_issue_fetch_buffer_pkg::*;

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   int   passed = 0;
   int   total = 0;

   dual_issue_fetch_buffer_if bus ();
   dual_issue_fetch_buffer dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] instr_of(input logic [21:0] pc);
      return 32'hA500_0000 ^ {10'd0, pc};
   endfunction

   task automatic cyc(input logic v, input logic [21:0] pc, input logic [1:0] dq, input logic fl);
      bus.enq_v_i = v;
      bus.enq_pc_i = pc;
      bus.enq_instr_i = instr_of(pc);
      bus.deq_count_i = dq;
      bus.flush_i = fl;
      @(posedge clk_i); #1;
      bus.enq_v_i = 1'b0;
      bus.deq_count_i = 2'd0;
      bus.flush_i = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (bus.v_o !== 2'b00) $display("FAIL reset_v got %b want 00", bus.v_o); else passed++;
      total++; if (bus.enq_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.enq_ready_o); else passed++;
      total++; if (bus.count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count_o); else passed++;
      #11 reset_n_i = 1'b1;
      @(posedge clk_i); #1;
      total++; if (bus.count_o !== 3'd0) $display("FAIL post_reset_count got %0d want 0", bus.count_o); else passed++;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) cyc(1'b1, 22'h100 + 22'(i), 2'd0, 1'b0);
      total++; if (bus.count_o !== 3'd4) $display("FAIL fill_count got %0d want 4", bus.count_o); else passed++;
      total++; if (bus.enq_ready_o !== 1'b0) $display("FAIL fill_ready got %b want 0", bus.enq_ready_o); else passed++;
      cyc(1'b1, 22'h104, 2'd0, 1'b0);
      total++; if (bus.count_o !== 3'd4) $display("FAIL fill_block_count got %0d want 4", bus.count_o); else passed++;
      total++; if (bus.v_o !== 2'b11) $display("FAIL fill_v got %b want 11", bus.v_o); else passed++;
      total++; if (bus.pc_o[0] !== 22'h100) $display("FAIL fill_pc0 got %h want 100", bus.pc_o[0]); else passed++;
      total++; if (bus.pc_o[1] !== 22'h101) $display("FAIL fill_pc1 got %h want 101", bus.pc_o[1]); else passed++;
      total++; if (bus.instr_o[1] !== instr_of(22'h101)) $display("FAIL fill_instr1 got %h want %h", bus.instr_o[1], instr_of(22'h101)); else passed++;
   endtask

   task automatic test_retire();
      cyc(1'b0, 22'h0, 2'd1, 1'b0);
      total++; if (bus.pc_o[0] !== 22'h101) $display("FAIL single_pc0 got %h want 101", bus.pc_o[0]); else passed++;
      total++; if (bus.count_o !== 3'd3) $display("FAIL single_count got %0d want 3", bus.count_o); else passed++;
      total++; if (bus.enq_ready_o !== 1'b1) $display("FAIL single_ready got %b want 1", bus.enq_ready_o); else passed++;
      cyc(1'b0, 22'h0, 2'd2, 1'b0);
      total++; if (bus.pc_o[0] !== 22'h103) $display("FAIL dual_pc0 got %h want 103", bus.pc_o[0]); else passed++;
      total++; if (bus.instr_o[0] !== instr_of(22'h103)) $display("FAIL dual_instr0 got %h want %h", bus.instr_o[0], instr_of(22'h103)); else passed++;
      total++; if (bus.v_o !== 2'b01) $display("FAIL dual_v got %b want 01", bus.v_o); else passed++;
      total++; if (bus.count_o !== 3'd1) $display("FAIL dual_count got %0d want 1", bus.count_o); else passed++;
      cyc(1'b0, 22'h0, 2'd1, 1'b0);
      total++; if (bus.count_o !== 3'd0) $display("FAIL drain_count got %0d want 0", bus.count_o); else passed++;
   endtask

   task automatic test_wrap();
      logic        tv [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [21:0] tp [11] = '{'h40B, 'h40C, 'h40D, 'h40E, 'h40F, 'h410, 'h411, 'h412, 'h413, 'h413, 'h0};
      logic [1:0]  td [11] = '{0, 0, 2, 0, 2, 0, 1, 0, 2, 2, 2};
      logic [2:0]  ec [11] = '{2, 3, 2, 3, 2, 3, 3, 4, 2, 1, 0};
      logic [1:0]  ev [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
      logic [21:0] ep [11] = '{'h40A, 'h40A, 'h40C, 'h40C, 'h40E, 'h40E, 'h40F, 'h40F, 'h411, 'h413, 'h0};
      cyc(1'b1, 22'h400, 2'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 22'h401 + 22'(i), 2'd1, 1'b0);
         total++; if (bus.count_o !== 3'd1) $display("FAIL steady_count[%0d] got %0d want 1", i, bus.count_o); else passed++;
         total++; if (bus.pc_o[0] !== 22'h401 + 22'(i)) $display("FAIL steady_pc0[%0d] got %h want %h", i, bus.pc_o[0], 22'h401 + 22'(i)); else passed++;
      end
      for (int i = 0; i < 11; i++) begin
         cyc(tv[i], tp[i], td[i], 1'b0);
         total++; if (bus.count_o !== ec[i]) $display("FAIL wrap_count[%0d] got %0d want %0d", i, bus.count_o, ec[i]); else passed++;
         total++; if (bus.v_o !== ev[i]) $display("FAIL wrap_v[%0d] got %b want %b", i, bus.v_o, ev[i]); else passed++;
         total++; if (bus.enq_ready_o !== (ec[i] != 3'd4)) $display("FAIL wrap_ready[%0d] got %b want %b", i, bus.enq_ready_o, ec[i] != 3'd4); else passed++;
         if (ev[i][0]) begin
            total++; if (bus.pc_o[0] !== ep[i]) $display("FAIL wrap_pc0[%0d] got %h want %h", i, bus.pc_o[0], ep[i]); else passed++;
         end
         if (ev[i][1]) begin
            total++; if (bus.pc_o[1] !== ep[i] + 22'd1) $display("FAIL wrap_pc1[%0d] got %h want %h", i, bus.pc_o[1], ep[i] + 22'd1); else passed++;
         end
      end
   endtask

   task automatic test_clamp();
      bus.enq_v_i = 1'b1;
      bus.enq_pc_i = 22'h200;
      bus.enq_instr_i = instr_of(22'h200);
      #1;
      total++; if (bus.v_o !== 2'b00) $display("FAIL no_bypass_v got %b want 00", bus.v_o); else passed++;
      @(posedge clk_i); #1;
      bus.enq_v_i = 1'b0;
      total++; if (bus.pc_o[0] !== 22'h200) $display("FAIL clamp_pc0 got %h want 200", bus.pc_o[0]); else passed++;
      total++; if (bus.v_o !== 2'b01) $display("FAIL clamp_v_pre got %b want 01", bus.v_o); else passed++;
      cyc(1'b0, 22'h0, 2'd2, 1'b0);
      total++; if (bus.count_o !== 3'd0) $display("FAIL clamp_count got %0d want 0", bus.count_o); else passed++;
      total++; if (bus.v_o !== 2'b00) $display("FAIL clamp_v got %b want 00", bus.v_o); else passed++;
      cyc(1'b0, 22'h0, 2'd1, 1'b0);
      total++; if (bus.count_o !== 3'd0) $display("FAIL underflow_count got %0d want 0", bus.count_o); else passed++;
      total++; if (bus.enq_ready_o !== 1'b1) $display("FAIL underflow_ready got %b want 1", bus.enq_ready_o); else passed++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) cyc(1'b1, 22'h2FD + 22'(i), 2'd0, 1'b0);
      total++; if (bus.count_o !== 3'd3) $display("FAIL preflush_count got %0d want 3", bus.count_o); else passed++;
      cyc(1'b1, 22'h300, 2'd2, 1'b1);
      total++; if (bus.count_o !== 3'd0) $display("FAIL flush_count got %0d want 0", bus.count_o); else passed++;
      total++; if (bus.v_o !== 2'b00) $display("FAIL flush_v got %b want 00", bus.v_o); else passed++;
      cyc(1'b0, 22'h0, 2'd0, 1'b0);
      total++; if (bus.v_o !== 2'b00) $display("FAIL flush_drop_v got %b want 00", bus.v_o); else passed++;
      cyc(1'b1, 22'h500, 2'd0, 1'b0);
      total++; if (bus.pc_o[0] !== 22'h500) $display("FAIL refetch_pc0 got %h want 500", bus.pc_o[0]); else passed++;
      total++; if (bus.v_o !== 2'b01) $display("FAIL refetch_v got %b want 01", bus.v_o); else passed++;
      cyc(1'b0, 22'h0, 2'd1, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cyc(1'b1, 22'h010 + 22'(i), 2'd0, 1'b0);
      total++; if (bus.count_o !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", bus.count_o); else passed++;
      reset_n_i = 1'b0;
      #1;
      total++; if (bus.v_o !== 2'b00) $display("FAIL mid_reset_v got %b want 00", bus.v_o); else passed++;
      total++; if (bus.enq_ready_o !== 1'b1) $display("FAIL mid_reset_ready got %b want 1", bus.enq_ready_o); else passed++;
      total++; if (bus.count_o !== 3'd0) $display("FAIL mid_reset_count got %0d want 0", bus.count_o); else passed++;
      #2 reset_n_i = 1'b1;
      @(posedge clk_i); #1;
      total++; if (bus.v_o !== 2'b00) $display("FAIL mid_release_v got %b want 00", bus.v_o); else passed++;
   endtask

   initial begin
      bus.enq_v_i = 1'b0;
      bus.enq_pc_i = '0;
      bus.enq_instr_i = '0;
      bus.deq_count_i = 2'd0;
      bus.flush_i = 1'b0;
      test_reset();
      test_fill();
      test_retire();
      test_wrap();
      test_clamp();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dual_issue_fetch_buffer.md
Name: dual_issue_fetch_buffer

Overview:
- Small instruction queue between the icache/fetch response path and the dual-issue decode stage.
- Accepts one fetched instruction per cycle with a valid/ready handshake.
- Always presents the two oldest instructions (slot 0 = older) to the dual decoder.
- Each cycle, the decoder reports how many instructions it consumed: 0 = stall, 1 = single-issue, 2 = dual-issue. The buffer retires that many.
- Flush discards all contents on a PC redirect (branch, jal/jalr, mret, interrupt).

Parameters:
- els_p, 4: queue depth in entries; power of two, ≥ 2.
- pc_width_p, 22: word-address PC width (byte PC >> 2).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- enq_v_i  in  1  fetched instruction valid.
- enq_instr_i  in  32  fetched instruction (instruction_s).
- enq_pc_i  in  pc_width_p  word PC of the fetched instruction.
- enq_ready_o  out  1  buffer can accept an instruction this cycle.
- instr_o[0:1]  out  2x32  oldest and second-oldest instructions; feeds decoder instruction_i[0:1].
- pc_o[0:1]  out  2 x pc_width_p  PCs of the slots.
- v_o[0:1]  out  2x1  slot valid; v_o[1] implies v_o[0].
- deq_count_i  in  2  instructions consumed this cycle (0, 1, 2; 3 is illegal).
- flush_i  in  1  discard all entries.
- count_o  out  $clog2(els_p+1)  current occupancy.

Behaviour:
- Storage: els_p entries of {pc, instr}; read pointer rptr, write pointer wptr (each $clog2(els_p) bits, wrap modulo els_p); occupancy counter cnt (0..els_p).
- Reset, asynchronous on reset_n_i low: rptr = wptr = cnt = 0.
  - Outputs during reset: enq_ready_o = 1, v_o = 2'b00, count_o = 0.
  - Storage contents are not reset.
  - instr_o/pc_o are don't-care when the matching v_o = 0. The bench must not check them.
- enq_ready_o = (cnt < els_p). It is registered-state-derived and does not depend on deq_count_i in the same cycle (no full-pass-through).
- Enqueue fires when enq_v_i & enq_ready_o & ~flush_i: write at wptr, then wptr+1.
- Dequeue amount: d = min(deq_count_i, number of valid slots), where valid slots = min(cnt, 2).
  - Over-dequeue is clamped; rptr += d.
  - deq_count_i = 3 is treated as 2 and fires an assertion in simulation.
- Next occupancy: cnt_next = cnt + enq_fire - d.
  - Simultaneous enqueue and dequeue are legal in the same cycle, including when cnt = els_p - 1.
- Output slots:
  - slot k = entry at rptr+k (mod els_p).
  - v_o[0] = (cnt ≥ 1); v_o[1] = (cnt ≥ 2).
- Latency: an enqueued instruction is first visible on the outputs the cycle after enq fire. There is no bypass from enq_*_i to the outputs.
- Flush: has priority over enqueue and dequeue.
  - Next cycle: rptr = wptr = cnt = 0 and v_o = 0.
  - An enq_v_i asserted in the flush cycle is dropped; fetch must re-request.
- Wrap-around: slot 1 may sit at physical index 0 while slot 0 sits at index els_p-1; output muxing must handle this.
- Invariant: pc_o[1] == pc_o[0] + 1 whenever v_o[1], because fetch is sequential within a flush epoch.
  - Checked by a simulation assertion only; there is no RTL correction.
- Single-issue sequencing is owned downstream. The buffer only honours deq_count_i and keeps no issue state.

Decomposition:
- bsg_vanilla_pkg gains typedef fetch_entry_s {logic [pc_width_p-1:0] pc; instruction_s instr;}.
  - The default depth constant fetch_buf_els_gp = 4 also lives in the package.
- No sub-module. Pointer/counter logic and the 2-read-port mux stay inline.
- Assertions are in a bind-able section guarded by synthesis translate_off.

Test Plan:
- Reset then idle: reset_n_i low mid-operation with cnt = 3 → same cycle v_o = 00, enq_ready_o = 1, count_o = 0.
- Fill and block:
  - Enqueue PCs 0x100..0x103 on four consecutive cycles with deq_count_i = 0 → count_o = 4 and enq_ready_o = 0.
  - 5th enq_v_i is not accepted.
  - Then pc_o = {0x100, 0x101} and v_o = 11.
- Single vs dual retire: from full at 0x100..0x103, deq_count_i = 1 then 2 → pc_o[0] = 0x101, then 0x103 with v_o = 01, count_o = 1.
- Wrap and simultaneous events:
  - Steady state: enq one per cycle, deq 1 per cycle for 10 cycles, then alternate deq 2 with enq.
  - Required: PC order preserved across the pointer wrap; count_o never exceeds 4 and never underflows.
- Over-dequeue clamp: cnt = 1 (pc 0x200), deq_count_i = 2 → next cycle count_o = 0, v_o = 00, no underflow.
- Flush priority: cnt = 3 with enq_v_i = 1 (pc 0x300), deq_count_i = 2, flush_i = 1 → next cycle count_o = 0 and v_o = 00.
  - 0x300 is never presented on the outputs.
